// File: rtl/vram_arbiter.sv
// Single-port frame memory arbiter: display prefetch always wins, writers share the rest round-robin.
// Optional macro VRAM_VBLANK_WR_ONLY_EN restricts writes to vertical blanking.
module vram_arbiter #(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int PPW      = 4,
    parameter int H_ACTIVE = 1024,
    parameter int H_TOTAL  = 1344,
    parameter int V_ACTIVE = 768,
    parameter int V_TOTAL  = 806,
    parameter int RD_LAT   = 2
) (
    input  logic                     vclock,
    input  logic                     reset_n,
    input  logic [10:0]              hcount,
    input  logic [9:0]               vcount,
    input  logic                     blank,
    input  logic [NREQ-1:0]          wr_req,
    input  logic [NREQ*ADDR_W-1:0]   wr_addr,
    input  logic [NREQ*DATA_W-1:0]   wr_data,
    output logic [NREQ-1:0]          wr_gnt,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W/PPW-1:0]    pix,
    output logic                     pix_blank
);
    localparam int W      = DATA_W / PPW;
    localparam int PPW_LG = $clog2(PPW);
    localparam int RR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int STAGES = RD_LAT;

    localparam logic [10:0] H_SLOT_MAX = 11'(H_ACTIVE - 2*PPW);
    localparam logic [10:0] H_LAST_ACT = 11'(H_ACTIVE - PPW);
    localparam logic [10:0] H_NEXT_LN  = 11'(H_TOTAL - PPW);
    localparam logic [10:0] H_END      = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_ACTIVE / PPW);

    if (RD_LAT < 1 || RD_LAT >= PPW) begin : g_lat_chk
        $error("vram_arbiter: RD_LAT must satisfy 1 <= RD_LAT < PPW");
    end

    typedef enum logic [1:0] {IDLE, DISP_RD, WR} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] req_addr [NREQ];
    logic [DATA_W-1:0] req_data [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign req_addr[i] = wr_addr[i*ADDR_W +: ADDR_W];
        assign req_data[i] = wr_data[i*DATA_W +: DATA_W];
    end

    logic [ADDR_W-1:0] line_base, next_base, rd_addr;
    logic [RR_W-1:0]   rr_ptr, gnt_idx, cand;
    logic [NREQ-1:0]   elig, gnt_nx;
    logic [9:0]        v_next, tgt_line;
    logic              fetch_next, disp_slot, wr_ok, found;
    logic [STAGES:0]   vld_pipe;
    logic [DATA_W-1:0] next_word, cur_word, src_sh;
    logic [PPW_LG-1:0] sel;

`ifdef VRAM_VBLANK_WR_ONLY_EN
    assign wr_ok = (vcount >= V_ACT);
`else
    assign wr_ok = 1'b1;
`endif

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        fetch_next = (hcount == H_NEXT_LN);
        v_next     = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        tgt_line   = fetch_next ? v_next : vcount;
        disp_slot  = ((hcount[PPW_LG-1:0] == '0 && hcount <= H_SLOT_MAX) ||
                      fetch_next || hcount == H_LAST_ACT) && (tgt_line < V_ACT);
        next_base  = (vcount == V_LAST) ? '0 : line_base + LINE_WORDS;
        rd_addr    = fetch_next ? next_base
                                : line_base + ADDR_W'(hcount >> PPW_LG) + ADDR_W'(1);
        // a requester still sees its own grant this cycle; don't serve it twice
        elig       = wr_req & ~wr_gnt & {NREQ{wr_ok}};
        found      = 1'b0;
        gnt_idx    = rr_ptr;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = RR_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && elig[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        state_nx = IDLE;
        if (disp_slot)  state_nx = DISP_RD;
        else if (found) state_nx = WR;
        gnt_nx = '0;
        if (state_nx == WR) gnt_nx[gnt_idx] = 1'b1;
        sel    = hcount[PPW_LG-1:0];
        src_sh = ((sel == '0) ? next_word : cur_word) >> (int'(sel) * W);
    end

    assign mem_we = (state == WR);

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            line_base <= '0;
            rr_ptr    <= '0;
            wr_gnt    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vld_pipe  <= '0;
            next_word <= '0;
            cur_word  <= '0;
            pix       <= '0;
            pix_blank <= 1'b1;
        end else begin
            if (hcount == H_END) line_base <= next_base;
            wr_gnt <= gnt_nx;
            if (state_nx == DISP_RD) begin
                mem_addr <= rd_addr;
            end else if (state_nx == WR) begin
                mem_addr  <= req_addr[gnt_idx];
                mem_wdata <= req_data[gnt_idx];
                rr_ptr    <= (gnt_idx == RR_W'(NREQ-1)) ? '0 : gnt_idx + RR_W'(1);
            end
            // bit k set: read data from the issue k+1 cycles ago is on mem_rdata at bit STAGES
            vld_pipe <= {vld_pipe[STAGES-1:0], state_nx == DISP_RD};
            if (vld_pipe[STAGES]) next_word <= mem_rdata;
            if (sel == '0) cur_word <= next_word;
            pix       <= blank ? '0 : src_sh[W-1:0];
            pix_blank <= blank;
        end
    end
endmodule
